mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage: branch resolve, wait-stated data memory, MEM/WB register (DMEM_WAIT_STATE_EN enables wait states).
// Latency: 1 cycle for non-memory ops; memory ops take WAIT_STATES+1 cycles when DMEM_WAIT_STATE_EN is defined, else 1.
// Backpressure: mem_stall holds upstream for WAIT_STATES cycles per access; MEM/WB takes bubbles (wb ctl 0) meanwhile.
module mem_stage #(
    parameter int WAIT_STATES = 2,
    parameter int DMEM_WORDS  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  EX_MEM_wb_ctlout,
    input  logic [2:0]  EX_MEM_m_ctlout,
    input  logic [31:0] EX_MEM_add_result,
    input  logic        EX_MEM_zero,
    input  logic [31:0] EX_MEM_alu_result,
    input  logic [31:0] EX_MEM_rdata2out,
    input  logic [4:0]  EX_MEM_five_bit_muxout,
    output logic        MEM_PCSrc,
    output logic [31:0] MEM_branch_target,
    output logic        mem_stall,
    output logic [1:0]  MEM_WB_wb_ctlout,
    output logic [31:0] MEM_WB_read_data,
    output logic [31:0] MEM_WB_alu_result,
    output logic [4:0]  MEM_WB_five_bit_muxout
);
    localparam int         AW  = $clog2(DMEM_WORDS);
    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    typedef struct packed {
        logic [1:0]  wb_ctl;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  dest;
    } memwb_t;

    memwb_t        memwb_q;
    logic [31:0]   dmem [DMEM_WORDS];
    logic [AW-1:0] idx;
    logic          mem_read;
    logic          mem_write;
    logic          mem_op;
    logic          stall;
    logic          unused_sink;

    assign mem_read  = EX_MEM_m_ctlout[1];
    assign mem_write = EX_MEM_m_ctlout[0];
    assign mem_op    = mem_read | mem_write;
    assign idx       = EX_MEM_alu_result[AW+1:2];

    assign MEM_PCSrc         = EX_MEM_m_ctlout[2] & EX_MEM_zero;
    assign MEM_branch_target = EX_MEM_add_result;

`ifdef DMEM_WAIT_STATE_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [3:0] CNT_INIT = WS4 - 4'd1;

    state_t     state;
    logic [3:0] cnt;

    // With a single wait state the IDLE cycle is the only stalled one, so BUSY is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        cnt   <= CNT_INIT;
                        state <= (CNT_INIT == 4'd0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stall must rise in the very cycle a memory op appears, hence the IDLE term.
    assign stall       = ((state == IDLE) && mem_op) || (state == BUSY);
    assign unused_sink = ^{EX_MEM_alu_result[31:AW+2], EX_MEM_alu_result[1:0]};
`else
    assign stall       = 1'b0;
    assign unused_sink = ^{EX_MEM_alu_result[31:AW+2], EX_MEM_alu_result[1:0], WS4};
`endif

    // Upstream inputs are still held in the completing cycle, so no latching is needed.
    assign mem_stall = stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_q <= '0;
        end else if (stall) begin
            memwb_q.wb_ctl <= 2'b00;
        end else begin
            memwb_q.wb_ctl     <= EX_MEM_wb_ctlout;
            memwb_q.read_data  <= mem_read ? dmem[idx] : 32'd0;
            memwb_q.alu_result <= EX_MEM_alu_result;
            memwb_q.dest       <= EX_MEM_five_bit_muxout;
        end
    end

    // Contents survive reset; a read-and-write instruction only reads.
    always_ff @(posedge clk) begin
        if (!stall && mem_write && !mem_read) begin
            dmem[idx] <= EX_MEM_rdata2out;
        end
    end

    assign MEM_WB_wb_ctlout       = memwb_q.wb_ctl;
    assign MEM_WB_read_data       = memwb_q.read_data;
    assign MEM_WB_alu_result      = memwb_q.alu_result;
    assign MEM_WB_five_bit_muxout = memwb_q.dest;
endmodule
